// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} arb_state_t;

  typedef enum logic {GNT_I, GNT_D} gnt_t;

  // Wide enough for MEM_LATENCY up to 15
  localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/mem_arbiter_latency_counter.sv
// Down-counter that times one memory access; flags the last cycle of the access.
// Latency: tc asserts loadVal-1 cycles after the load edge (same cycle as load result when loadVal=1).
// Backpressure: none; the arbiter FSM owns load and decrement.
module latency_counter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] cnt;

  // Load on grant, count down while a transfer is active; parks at zero
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == WIDTH'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-side refills and D-side accesses onto one memory port, round-robin on ties.
// Latency: Req sampled in IDLE, MEM_LATENCY busy cycles, Ack one cycle later; MEM_LATENCY+2 cycles per transaction.
// Backpressure: requesters hold Req until their Ack; StallI/StallD report the wait to the hazard unit.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_LATENCY   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IReq,
  input  logic [ADDRESS_WIDTH-1:0] IAddr,
  output logic [DATA_WIDTH-1:0]    IRData,
  output logic                     IAck,
  input  logic                     DReq,
  input  logic                     DWE,
  input  logic [ADDRESS_WIDTH-1:0] DAddr,
  input  logic [DATA_WIDTH-1:0]    DWData,
  output logic [DATA_WIDTH-1:0]    DRData,
  output logic                     DAck,
  output logic [ADDRESS_WIDTH-1:0] MemA,
  output logic [DATA_WIDTH-1:0]    MemWD,
  output logic                     MemWE,
  input  logic [DATA_WIDTH-1:0]    MemRD,
  output logic                     StallI,
  output logic                     StallD,
  output logic                     Busy
);

  arb_state_t               state;
  arb_state_t               stateNext;
  gnt_t                     lastGnt;
  logic                     grantI;
  logic                     grantD;
  logic                     xferActive;
  logic                     tc;
  logic [ADDRESS_WIDTH-1:0] addrReg;
  logic [DATA_WIDTH-1:0]    wdReg;
  logic                     weReg;
  logic [DATA_WIDTH-1:0]    iRDataReg;
  logic [DATA_WIDTH-1:0]    dRDataReg;

  assign xferActive = (state == IBUSY) || (state == DBUSY);

  // Grant decision: only in IDLE; on a tie the side not served last wins
  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    if (state == IDLE) begin
      if (IReq && DReq) begin
        if (lastGnt == GNT_I) grantD = 1'b1;
        else                  grantI = 1'b1;
      end else if (IReq) begin
        grantI = 1'b1;
      end else if (DReq) begin
        grantD = 1'b1;
      end
    end
  end

  // Next-state: DONE never samples requests since the old Req is still up
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (grantI)      stateNext = IBUSY;
        else if (grantD) stateNext = DBUSY;
      end
      IBUSY, DBUSY: begin
        if (tc) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  // Latch the granted request so later input changes cannot reach memory
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lastGnt <= GNT_I;
      addrReg <= '0;
      wdReg   <= '0;
      weReg   <= 1'b0;
    end else if (grantI) begin
      lastGnt <= GNT_I;
      addrReg <= IAddr;
    end else if (grantD) begin
      lastGnt <= GNT_D;
      addrReg <= DAddr;
      wdReg   <= DWData;
      weReg   <= DWE;
    end
  end

  // Capture read data on the final busy cycle; held until that side's next capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      iRDataReg <= '0;
      dRDataReg <= '0;
    end else if (xferActive && tc) begin
      if (state == IBUSY) iRDataReg <= MemRD;
      else                dRDataReg <= MemRD;
    end
  end

  latency_counter #(
    .WIDTH(CNT_WIDTH)
  ) uLatencyCounter (
    .CLK    (CLK),
    .RST    (RST),
    .load   (grantI || grantD),
    .loadVal(CNT_WIDTH'(MEM_LATENCY)),
    .dec    (xferActive),
    .tc     (tc)
  );

  // Single write strobe on the last DBUSY cycle; decoded from registers only
  assign MemWE  = (state == DBUSY) && tc && weReg;
  assign MemA   = addrReg;
  assign MemWD  = wdReg;
  assign Busy   = (state != IDLE);

  assign IAck   = (state == DONE) && (lastGnt == GNT_I);
  assign DAck   = (state == DONE) && (lastGnt == GNT_D);
  assign IRData = iRDataReg;
  assign DRData = dRDataReg;

  assign StallI = IReq && !IAck;
  assign StallD = DReq && !DAck;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at MEM_LATENCY=4 and MEM_LATENCY=1, each with a word memory model.
// Latency: stimulus driven 1ns after the rising edge, outputs sampled 3ns after it.
// Backpressure: bench requesters hold Req until Ack, then drop or re-present.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int nTests = 0;
  int nFail  = 0;

  // MEM_LATENCY = 4 instance
  logic        iReq = 1'b0, iAck, dReq = 1'b0, dWE = 1'b0, dAck, memWE, stallI, stallD, busy;
  logic [31:0] iAddr = '0, iRData, dAddr = '0, dWData = '0, dRData, memA, memWD, memRD;
  logic [31:0] mem4 [0:255];
  logic        pokeEn4 = 1'b0;
  logic [7:0]  pokeA4 = '0;
  logic [31:0] pokeD4 = '0;
  int          wc4 = 0;

  // MEM_LATENCY = 1 instance (I side only)
  logic        iReq1 = 1'b0, iAck1, dAck1, memWE1, stallI1, stallD1, busy1;
  logic        dReq1 = 1'b0, dWE1 = 1'b0;
  logic [31:0] iAddr1 = '0, iRData1, dRData1, memA1, memWD1, memRD1;
  logic [31:0] dAddr1 = '0, dWData1 = '0;
  logic [31:0] mem1 [0:255];
  logic        pokeEn1 = 1'b0;
  logic [7:0]  pokeA1 = '0;
  logic [31:0] pokeD1 = '0;

  mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_LATENCY(4)) dut4 (
    .CLK(CLK), .RST(RST),
    .IReq(iReq), .IAddr(iAddr), .IRData(iRData), .IAck(iAck),
    .DReq(dReq), .DWE(dWE), .DAddr(dAddr), .DWData(dWData), .DRData(dRData), .DAck(dAck),
    .MemA(memA), .MemWD(memWD), .MemWE(memWE), .MemRD(memRD),
    .StallI(stallI), .StallD(stallD), .Busy(busy)
  );

  mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .CLK(CLK), .RST(RST),
    .IReq(iReq1), .IAddr(iAddr1), .IRData(iRData1), .IAck(iAck1),
    .DReq(dReq1), .DWE(dWE1), .DAddr(dAddr1), .DWData(dWData1), .DRData(dRData1), .DAck(dAck1),
    .MemA(memA1), .MemWD(memWD1), .MemWE(memWE1), .MemRD(memRD1),
    .StallI(stallI1), .StallD(stallD1), .Busy(busy1)
  );

  // Memory models: combinational read, synchronous write, bench preload port
  assign memRD  = mem4[memA[7:0]];
  assign memRD1 = mem1[memA1[7:0]];

  always @(posedge CLK) begin
    if (pokeEn4)    mem4[pokeA4] <= pokeD4;
    else if (memWE) mem4[memA[7:0]] <= memWD;
  end

  always @(posedge CLK) begin
    if (pokeEn1)     mem1[pokeA1] <= pokeD1;
    else if (memWE1) mem1[memA1[7:0]] <= memWD1;
  end

  always @(posedge CLK) begin
    if (memWE) wc4 <= wc4 + 1;
  end

  task automatic poke4(input logic [7:0] a, input logic [31:0] d);
    pokeA4 = a; pokeD4 = d; pokeEn4 = 1'b1;
    @(posedge CLK); #1;
    pokeEn4 = 1'b0;
  endtask

  task automatic poke1(input logic [7:0] a, input logic [31:0] d);
    pokeA1 = a; pokeD1 = d; pokeEn1 = 1'b1;
    @(posedge CLK); #1;
    pokeEn1 = 1'b0;
  endtask

  task automatic test_reset;
    logic [9:0] obs;
    RST = 1'b1;
    #2;
    obs = {iAck, dAck, memWE, busy, stallI, stallD, iAck1, dAck1, busy1, memWE1};
    nTests++;
    if (obs !== 10'b0) begin
      nFail++; $display("FAIL reset_ctl got %b expected %b", obs, 10'b0);
    end
    nTests++;
    if ({memA, memWD, iRData, dRData} !== 128'b0) begin
      nFail++; $display("FAIL reset_data got %h %h %h %h expected all 0", memA, memWD, iRData, dRData);
    end
    nTests++;
    if ({memA1, iRData1, dRData1} !== 96'b0) begin
      nFail++; $display("FAIL reset_data1 got %h %h %h expected all 0", memA1, iRData1, dRData1);
    end
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    #2;
    nTests++;
    if ({busy, busy1} !== 2'b00) begin
      nFail++; $display("FAIL reset_release_busy got %b expected 00", {busy, busy1});
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_i_read;
    logic [2:0] obs, exp;
    poke4(8'h40, 32'hDEADBEEF);
    iAddr = 32'h40; iReq = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      #2;
      obs = {iAck, stallI, busy};
      exp = {c == 5, c <= 4, (c >= 1) && (c <= 5)};
      nTests++;
      if (obs !== exp) begin
        nFail++; $display("FAIL iread_ctl c=%0d {iAck,stallI,busy} got %b expected %b", c, obs, exp);
      end
      if (c == 3) begin
        nTests++;
        if (memA !== 32'h40) begin
          nFail++; $display("FAIL iread_memA got %h expected %h", memA, 32'h40);
        end
      end
      if (c == 5) begin
        nTests++;
        if (iRData !== 32'hDEADBEEF) begin
          nFail++; $display("FAIL iread_data got %h expected %h", iRData, 32'hDEADBEEF);
        end
      end
      @(posedge CLK); #1;
      if (c == 5) iReq = 1'b0;
    end
  endtask

  task automatic test_write_read;
    logic [2:0] obs, exp;
    int wcStart;
    poke4(8'h80, 32'hCAFEF00D);
    wcStart = wc4;
    dAddr = 32'h80; dWData = 32'h12345678; dWE = 1'b1; dReq = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      #2;
      obs = {dAck, memWE, busy};
      exp = {(c == 5) || (c == 11), c == 4, ((c >= 1) && (c <= 5)) || ((c >= 7) && (c <= 11))};
      nTests++;
      if (obs !== exp) begin
        nFail++; $display("FAIL wr_rd_ctl c=%0d {dAck,memWE,busy} got %b expected %b", c, obs, exp);
      end
      if (c == 4) begin
        nTests++;
        if ({memA, memWD} !== {32'h80, 32'h12345678}) begin
          nFail++; $display("FAIL wr_port got %h/%h expected %h/%h", memA, memWD, 32'h80, 32'h12345678);
        end
      end
      if (c == 5) begin
        nTests++;
        if (dRData !== 32'hCAFEF00D) begin
          nFail++; $display("FAIL wr_prewrite_rdata got %h expected %h", dRData, 32'hCAFEF00D);
        end
      end
      if (c == 11) begin
        nTests++;
        if (dRData !== 32'h12345678) begin
          nFail++; $display("FAIL rd_after_wr got %h expected %h", dRData, 32'h12345678);
        end
      end
      @(posedge CLK); #1;
      if (c == 5)  dWE  = 1'b0;
      if (c == 11) dReq = 1'b0;
    end
    nTests++;
    if ((wc4 - wcStart) != 1) begin
      nFail++; $display("FAIL wr_count got %0d expected %0d", wc4 - wcStart, 1);
    end
  endtask

  task automatic test_reset_mid_write;
    logic [1:0] obs, exp;
    int wcStart;
    poke4(8'h90, 32'h11111111);
    wcStart = wc4;
    dAddr = 32'h90; dWData = 32'hAAAA5555; dWE = 1'b1; dReq = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #2;
    nTests++;
    if (busy !== 1'b1) begin
      nFail++; $display("FAIL rstmid_busy_before got %b expected %b", busy, 1'b1);
    end
    RST = 1'b1; dReq = 1'b0; dWE = 1'b0;
    #1;
    nTests++;
    if ({iAck, dAck, memWE, busy} !== 4'b0) begin
      nFail++; $display("FAIL rstmid_ctl got %b expected %b", {iAck, dAck, memWE, busy}, 4'b0);
    end
    nTests++;
    if ({memA, memWD, iRData, dRData} !== 128'b0) begin
      nFail++; $display("FAIL rstmid_data got %h %h %h %h expected all 0", memA, memWD, iRData, dRData);
    end
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
    end
    nTests++;
    if (mem4[8'h90] !== 32'h11111111 || wc4 != wcStart) begin
      nFail++; $display("FAIL rstmid_nowrite got mem=%h writes=%0d expected mem=%h writes=0",
                        mem4[8'h90], wc4 - wcStart, 32'h11111111);
    end
    iAddr = 32'h90; iReq = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      #2;
      obs = {iAck, busy};
      exp = {c == 5, (c >= 1) && (c <= 5)};
      nTests++;
      if (obs !== exp) begin
        nFail++; $display("FAIL rstmid_next_ctl c=%0d {iAck,busy} got %b expected %b", c, obs, exp);
      end
      if (c == 5) begin
        nTests++;
        if (iRData !== 32'h11111111) begin
          nFail++; $display("FAIL rstmid_next_data got %h expected %h", iRData, 32'h11111111);
        end
      end
      @(posedge CLK); #1;
      if (c == 5) iReq = 1'b0;
    end
  endtask

  task automatic test_tie_alternate;
    logic [2:0] obs, exp;
    iAddr = 32'h40; dAddr = 32'h80; dWE = 1'b0;
    iReq = 1'b1; dReq = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      #2;
      obs = {dAck, iAck, stallI};
      exp = {(c == 5) || (c == 17), (c == 11) || (c == 23), (c <= 10) || ((c >= 12) && (c <= 22))};
      nTests++;
      if (obs !== exp) begin
        nFail++; $display("FAIL tie_ctl c=%0d {dAck,iAck,stallI} got %b expected %b", c, obs, exp);
      end
      if (c == 5 || c == 17) begin
        nTests++;
        if (dRData !== 32'h12345678) begin
          nFail++; $display("FAIL tie_ddata c=%0d got %h expected %h", c, dRData, 32'h12345678);
        end
      end
      if (c == 11 || c == 23) begin
        nTests++;
        if (iRData !== 32'hDEADBEEF) begin
          nFail++; $display("FAIL tie_idata c=%0d got %h expected %h", c, iRData, 32'hDEADBEEF);
        end
      end
      @(posedge CLK); #1;
      if (c == 23) begin
        iReq = 1'b0; dReq = 1'b0;
      end
    end
  endtask

  task automatic test_d_during_ibusy;
    logic [2:0] obs, exp;
    poke4(8'h88, 32'h55AA55AA);
    iAddr = 32'h40; iReq = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c == 1) dAddr = 32'h44;
      if (c == 3) begin
        dAddr = 32'h88; dWE = 1'b0; dReq = 1'b1;
      end
      #2;
      obs = {iAck, dAck, stallD};
      exp = {c == 5, c == 11, (c >= 3) && (c <= 10)};
      nTests++;
      if (obs !== exp) begin
        nFail++; $display("FAIL dwait_ctl c=%0d {iAck,dAck,stallD} got %b expected %b", c, obs, exp);
      end
      if (c >= 1 && c <= 4) begin
        nTests++;
        if (memA !== 32'h40) begin
          nFail++; $display("FAIL dwait_memA_i c=%0d got %h expected %h", c, memA, 32'h40);
        end
      end
      if (c >= 7 && c <= 10) begin
        nTests++;
        if (memA !== 32'h88) begin
          nFail++; $display("FAIL dwait_memA_d c=%0d got %h expected %h", c, memA, 32'h88);
        end
      end
      if (c == 11) begin
        nTests++;
        if (dRData !== 32'h55AA55AA) begin
          nFail++; $display("FAIL dwait_data got %h expected %h", dRData, 32'h55AA55AA);
        end
      end
      @(posedge CLK); #1;
      if (c == 5)  iReq = 1'b0;
      if (c == 11) dReq = 1'b0;
    end
  endtask

  task automatic test_latency1;
    logic [1:0]  obs, exp;
    logic [31:0] addrList [3];
    logic [31:0] dataList [3];
    int idx;
    addrList[0] = 32'h10; addrList[1] = 32'h11; addrList[2] = 32'h10;
    dataList[0] = 32'h0BADF00D; dataList[1] = 32'h600DCAFE; dataList[2] = 32'h0BADF00D;
    poke1(8'h10, 32'h0BADF00D);
    poke1(8'h11, 32'h600DCAFE);
    idx = 0;
    iAddr1 = addrList[0]; iReq1 = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      #2;
      obs = {iAck1, busy1};
      exp = {(c == 2) || (c == 5) || (c == 8), ((c % 3) != 0) && (c <= 8)};
      nTests++;
      if (obs !== exp) begin
        nFail++; $display("FAIL lat1_ctl c=%0d {iAck,busy} got %b expected %b", c, obs, exp);
      end
      if (exp[1]) begin
        nTests++;
        if (iRData1 !== dataList[idx]) begin
          nFail++; $display("FAIL lat1_data c=%0d got %h expected %h", c, iRData1, dataList[idx]);
        end
      end
      @(posedge CLK); #1;
      if (exp[1]) begin
        idx++;
        if (idx == 3) iReq1 = 1'b0;
        else          iAddr1 = addrList[idx];
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_i_read();
    test_write_read();
    test_reset_mid_write();
    test_tie_alternate();
    test_d_during_ibusy();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared data memory (word-wide, synchronous write, combinational read). Instruction-side refill requests and data-side cache-miss/write-through requests are serialised onto the one memory port with round-robin fairness. Each transaction is held for a fixed `MEM_LATENCY` cycles to model slow main memory. Per-side stall signals go to the hazard unit, and captured read data goes back to the requester.

## Interface
- `DATA_WIDTH`, 32, word width of all data buses
- `ADDRESS_WIDTH`, 32, width of all address buses
- `MEM_LATENCY`, 4, memory access time in cycles; legal range 1..15
- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `IReq`  in  1  instruction-side request; held until `IAck`
- `IAddr`  in  ADDRESS_WIDTH  instruction-side word address
- `IRData`  out  DATA_WIDTH  instruction-side read data; valid while `IAck`=1
- `IAck`  out  1  instruction-side completion, one-cycle pulse
- `DReq`  in  1  data-side request; held until `DAck`
- `DWE`  in  1  data-side write enable (1 = write)
- `DAddr`  in  ADDRESS_WIDTH  data-side address
- `DWData`  in  DATA_WIDTH  data-side write data
- `DRData`  out  DATA_WIDTH  data-side read data; valid while `DAck`=1
- `DAck`  out  1  data-side completion, one-cycle pulse
- `MemA`  out  ADDRESS_WIDTH  memory address
- `MemWD`  out  DATA_WIDTH  memory write data
- `MemWE`  out  1  memory write enable
- `MemRD`  in  DATA_WIDTH  memory read data, combinational from `MemA`
- `StallI`  out  1  `IReq & ~IAck`, combinational
- `StallD`  out  1  `DReq & ~DAck`, combinational
- `Busy`  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: no transaction.
  - IBUSY: instruction-side transaction in progress.
  - DBUSY: data-side transaction in progress.
  - DONE: one-cycle completion state.
- IDLE:
  - Only `IReq`: grant I, go to IBUSY.
  - Only `DReq`: grant D, go to DBUSY.
  - Both: grant the side not granted last (`last_gnt` register, reset value I, so D wins the first tie).
  - Neither: stay in IDLE.
- On grant:
  - Latch address, write data and `DWE` into internal registers (write data and write enable are latched for D only).
  - Load latency counter `cnt` with `MEM_LATENCY`.
  - Update `last_gnt`.
- IBUSY/DBUSY:
  - `cnt` decrements every cycle.
  - `MemA`/`MemWD` are driven from the latched registers.
  - When `cnt`==1: capture `MemRD` into the granted side's RData register and go to DONE.
- `MemWE` is high only in the single DBUSY cycle with `cnt`==1 and latched write enable =1. Exactly one memory write per write transaction.
- DONE:
  - Granted side's Ack is high for exactly one cycle; then go to IDLE.
  - Requests are not sampled in DONE, because the requester's Req is still the old transaction during that cycle.
- Requester contract:
  - Req, Addr, WE and WData must be held stable from assertion until the Ack cycle.
  - After an Ack edge the requester either drops Req or presents a new transaction.
  - Input changes while a transaction is granted are ignored, because all values are latched.
- RData registers hold their value until the next capture for that side.
- Writes return the pre-write `MemRD` in `DRData`; requesters ignore it.

## Timing
- Reset (async, immediate):
  - state=IDLE, `cnt`=0, `last_gnt`=I.
  - `IAck`=`DAck`=`MemWE`=`Busy`=0.
  - `MemA`, `MemWD`, `IRData`, `DRData` = 0.
- Reset mid-transaction: abort with no Ack. A write is committed only if its `MemWE` edge already occurred.
- Latency: Req sampled in IDLE at cycle 0 → BUSY for cycles 1..`MEM_LATENCY` → Ack in cycle `MEM_LATENCY`+1. Stall is high for `MEM_LATENCY`+1 cycles.
- Back-to-back throughput: the earliest next grant is at cycle `MEM_LATENCY`+2 (IDLE). Each transaction occupies `MEM_LATENCY`+2 cycles.
- `MEM_LATENCY`=1: one BUSY cycle, with load and terminal count in the same cycle.
- A request that arrives while the other side is busy waits. With both continuously requesting, grants strictly alternate.
- `Busy`, `MemA`, `MemWD` and `MemWE` are registered or state-decoded, so no combinational path runs from the Req inputs to memory.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} arb_state_t`
  - `typedef enum logic {GNT_I, GNT_D} gnt_t`
  - `localparam CNT_WIDTH = 4`
- Sub-module `latency_counter`: load, decrement enable, and terminal-count (`cnt`==1) output; width `CNT_WIDTH`.
- All FSM, grant and latch logic lives in `mem_arbiter`.

## Test plan
- Reset mid-DBUSY write with `MEM_LATENCY`=4: assert `RST` at BUSY cycle 2 → all outputs 0, no `MemWE` pulse, state IDLE. The next `IReq` is granted normally.
- `MEM_LATENCY`=4, preload mem[0x40]=0xDEADBEEF; `IReq` with `IAddr`=0x40 → `IAck` high only in cycle 5, `IRData`=0xDEADBEEF, `StallI` high in cycles 0..4, `Busy` high in cycles 1..5.
- D write `DAddr`=0x80, `DWData`=0x12345678, then D read of 0x80 → exactly one `MemWE` cycle (cycle 4); the read returns 0x12345678 with `DAck` in cycle 11.
- `IReq` and `DReq` rise together after reset, both held → D granted first (`DAck` cycle 5), then I (`IAck` cycle 11). Continued requests alternate D, I, D, I.
- `DReq` arrives during IBUSY → no grant until IDLE; `DAck` comes `MEM_LATENCY`+1 cycles after the I transaction's DONE+1. Changes to `DAddr` during IBUSY have no effect on `MemA`.
- `MEM_LATENCY`=1: single I read → `IAck` in cycle 2; back-to-back reads complete every 3 cycles.
